sed_scheduler: RTL
==================

# sed_scheduler

Controller that sequences the SEDGA soft-error-detection primitive for ECP5U/M designs. Powers SEDGA up, launches configuration-memory CRC checks periodically or on request, and performs the START/INPROG/DONE handshake across SEDGA's own oscillator domain. Optionally injects a forced error, and reports results as sticky flags, a saturating error count and per-check pulses. Sits between fabric control logic and the SEDGA instance; it is the only driver of SEDGA's inputs.

## Interface
Parameters:
- INTERVAL, 0: CLK cycles between automatic checks, measured from the end of one check to the start of the next; 0 = request-only.
- WARMUP_CYC, 64: CLK cycles after SEDENABLE rises before the first SEDSTART.
- TIMEOUT_CYC, 2**24: CLK-cycle watchdog per handshake phase.
- ERRCNT_W, 8: width of ERRCNT.

Ports:
- CLK  in  1  free-running fabric clock; not SEDCLKOUT.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  controller enable; low forces DISABLED.
- REQ  in  1  single-cycle check request.
- INJ  in  1  level; sampled at check launch, forces an error on that check.
- CLR  in  1  single-cycle clear of ERRFLAG, TOFLAG and ERRCNT.
- SEDENABLE  out  1  to SEDGA.
- SEDSTART  out  1  to SEDGA.
- SEDFRCERR  out  1  to SEDGA.
- SEDDONE, SEDINPROG, SEDERR  in  1 each  from SEDGA (asynchronous to CLK).
- BUSY  out  1  high from launch until return to IDLE.
- CHKDONE  out  1  one-cycle pulse per completed check.
- CHKERR  out  1  valid with CHKDONE; error result of that check.
- ERRFLAG  out  1  sticky error.
- TOFLAG  out  1  sticky watchdog timeout.
- ERRCNT  out  ERRCNT_W  saturating count of failed checks.

## Operation
- The three SEDGA status inputs pass through 2-flop synchronizers; all logic uses the synchronized versions (sdone, sinprog, serr).
- FSM states:
  - DISABLED -> WARMUP when EN = 1.
  - WARMUP: SEDENABLE = 1; after WARMUP_CYC cycles -> IDLE.
  - IDLE -> LAUNCH when the pending bit is set.
  - LAUNCH: SEDSTART = 1, SEDFRCERR = INJ latched; -> RUN on sinprog = 1.
  - RUN: SEDSTART held high; -> SETTLE on rising sdone.
  - SETTLE: 2 cycles, then sample serr -> RELEASE.
  - RELEASE: SEDSTART = 0, SEDFRCERR = 0; -> IDLE on sinprog = 0.
- Pending bit: set by REQ or interval-timer expiry, cleared on entering LAUNCH. One deep; extra requests while pending or BUSY are merged.
- The interval timer counts only in IDLE and reloads on leaving RELEASE.
- Check result: CHKERR = serr sampled at end of SETTLE. If CHKERR = 1, set ERRFLAG and increment ERRCNT, saturating at all-ones.
- Watchdog: a per-phase counter runs in LAUNCH, RUN and RELEASE. On reaching TIMEOUT_CYC:
  - set TOFLAG and pulse CHKDONE with CHKERR = 1;
  - ERRCNT increments;
  - drop SEDENABLE and go to WARMUP, which re-powers SEDGA and clears its internal state.
- EN falling in any state: next cycle DISABLED, all SEDGA outputs 0, pending cleared, no CHKDONE. Sticky flags and ERRCNT are kept.
- CLR in the same cycle as a new error: the clear applies first, then the error, giving ERRCNT = 1 and ERRFLAG = 1.

## Timing
- Reset values: every output 0, FSM DISABLED, pending 0, timers 0.
- Synchronizer latency is 2 CLK. SEDSTART stays high until sinprog is seen, so SEDGA samples it regardless of the CLK/SEDCLKOUT ratio.
- From REQ in IDLE, SEDSTART rises on the next cycle; BUSY rises on the same cycle.
- CHKDONE is asserted 3 cycles after rising sdone and is a single cycle. Flag and counter updates are visible the cycle after CHKDONE.
- REQ in the cycle IDLE exits is merged into that launch.

## Structure
- Package sed_sched_pkg holds:
  - the FSM state enum;
  - the SETTLE length constant (2);
  - the synchronizer depth constant (2).
- Sub-module sed_sync: a parameterized-width 2-flop synchronizer, instantiated once with width 3.
- The FSM, timers and counters live in sed_scheduler.

## Test plan
- EN = 1, WARMUP_CYC = 64, REQ at cycle 100 with a SEDGA model (DONE after 50 SED clocks) -> one CHKDONE, CHKERR = 0, ERRCNT = 0, BUSY low afterwards.
- INJ = 1 plus REQ -> SEDFRCERR high during the check, CHKERR = 1, ERRFLAG = 1, ERRCNT = 1; CLR -> all 0.
- INTERVAL = 1000, no REQ -> CHKDONE pulses spaced by check duration + 1000 + launch overhead; three REQs during BUSY add exactly one extra check.
- SEDGA model that never raises INPROG, TIMEOUT_CYC = 500 -> TOFLAG = 1, ERRCNT = 1, SEDENABLE low for 1 cycle and then WARMUP.
- EN drop in RUN -> next cycle SEDENABLE = SEDSTART = 0 and no CHKDONE; RST mid-check -> all outputs 0 on the next edge.
- ERRCNT_W = 2 with 5 injected checks -> ERRCNT saturates at 3.

Source files
------------

// File: rtl/sed_sched_pkg.sv
// Shared types and constants for the SEDGA check scheduler.
//   state_t    : scheduler FSM states
//   SETTLE_LEN : cycles spent settling after SEDDONE rises, before sampling SEDERR
//   SYNC_DEPTH : flop stages on the SEDGA status inputs
package sed_sched_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_WARMUP   = 3'd1,
        ST_IDLE     = 3'd2,
        ST_LAUNCH   = 3'd3,
        ST_RUN      = 3'd4,
        ST_SETTLE   = 3'd5,
        ST_RELEASE  = 3'd6
    } state_t;

    localparam int unsigned SETTLE_LEN = 2;
    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/sed_sync.sv
// Multi-flop synchronizer for SEDGA status bits crossing from the SEDCLKOUT domain.
//   clk : destination clock
//   rst : synchronous active-high reset
//   d   : asynchronous inputs
//   q   : synchronized outputs (SYNC_DEPTH cycles of latency)
module sed_sync
    import sed_sched_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [SYNC_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/sed_scheduler.sv
// Sequencer for the SEDGA soft-error-detection primitive: power-up warmup,
// periodic/requested CRC checks with START/INPROG/DONE handshake, optional
// forced error, per-phase watchdog and sticky result reporting.
//   CLK, RST                      : fabric clock, synchronous active-high reset
//   EN, REQ, INJ, CLR             : enable, check request, error inject, clear
//   SEDENABLE/SEDSTART/SEDFRCERR  : drive SEDGA
//   SEDDONE/SEDINPROG/SEDERR      : SEDGA status (async)
//   BUSY, CHKDONE, CHKERR         : check in progress, per-check pulse and result
//   ERRFLAG, TOFLAG, ERRCNT       : sticky error, sticky timeout, saturating count
module sed_scheduler
    import sed_sched_pkg::*;
#(
    parameter int unsigned INTERVAL    = 0,
    parameter int unsigned WARMUP_CYC  = 64,
    parameter int unsigned TIMEOUT_CYC = 2**24,
    parameter int unsigned ERRCNT_W    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                REQ,
    input  logic                INJ,
    input  logic                CLR,
    output logic                SEDENABLE,
    output logic                SEDSTART,
    output logic                SEDFRCERR,
    input  logic                SEDDONE,
    input  logic                SEDINPROG,
    input  logic                SEDERR,
    output logic                BUSY,
    output logic                CHKDONE,
    output logic                CHKERR,
    output logic                ERRFLAG,
    output logic                TOFLAG,
    output logic [ERRCNT_W-1:0] ERRCNT
);

    localparam int unsigned WARM_W = $clog2(WARMUP_CYC + 2);
    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 2);
    localparam int unsigned IVL_W  = $clog2(INTERVAL + 2);
    localparam int unsigned SET_W  = $clog2(SETTLE_LEN + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [IVL_W-1:0]  IVL_LAST  = IVL_W'((INTERVAL > 0) ? INTERVAL - 1 : 0);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_LEN - 1);

    state_t              state;
    logic                pending;
    logic [WARM_W-1:0]   warm_cnt;
    logic [WD_W-1:0]     wd_cnt;
    logic [IVL_W-1:0]    ivl_cnt;
    logic [SET_W-1:0]    set_cnt;
    logic                sdone, sinprog, serr, sdone_q;
    logic                to_evt;
    logic [2:0]          sync_q;

    logic                ivl_exp, launch_req, wd_active, phase_exit, wd_fire, err_evt;
    logic [ERRCNT_W-1:0] cnt_base;

    sed_sync #(.W(3)) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   ({SEDDONE, SEDINPROG, SEDERR}),
        .q   (sync_q)
    );
    assign {sdone, sinprog, serr} = sync_q;

    // Interval timer only counts in IDLE, so expiry is only meaningful there.
    assign ivl_exp    = (INTERVAL != 0) && (state == ST_IDLE) && (ivl_cnt == IVL_LAST);
    // REQ/expiry in the IDLE exit cycle are folded into this launch.
    assign launch_req = pending | REQ | ivl_exp;

    // Which phases are watched, and the condition that ends each one.
    always_comb begin
        wd_active  = 1'b0;
        phase_exit = 1'b0;
        case (state)
            ST_LAUNCH:  begin wd_active = 1'b1; phase_exit = sinprog;            end
            ST_RUN:     begin wd_active = 1'b1; phase_exit = sdone & ~sdone_q;   end
            ST_RELEASE: begin wd_active = 1'b1; phase_exit = ~sinprog;           end
            default:    ;
        endcase
    end

    assign wd_fire = wd_active && !phase_exit && (wd_cnt == WD_LAST);

    // Scheduler FSM with its timers and the SEDGA-facing outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_DISABLED;
            pending   <= 1'b0;
            warm_cnt  <= '0;
            wd_cnt    <= '0;
            ivl_cnt   <= '0;
            set_cnt   <= '0;
            sdone_q   <= 1'b0;
            to_evt    <= 1'b0;
            SEDENABLE <= 1'b0;
            SEDSTART  <= 1'b0;
            SEDFRCERR <= 1'b0;
            BUSY      <= 1'b0;
            CHKDONE   <= 1'b0;
            CHKERR    <= 1'b0;
        end else begin
            CHKDONE <= 1'b0;
            to_evt  <= 1'b0;
            sdone_q <= sdone;
            if (REQ || ivl_exp) pending <= 1'b1;

            if (!EN) begin
                state     <= ST_DISABLED;
                pending   <= 1'b0;
                warm_cnt  <= '0;
                wd_cnt    <= '0;
                ivl_cnt   <= '0;
                SEDENABLE <= 1'b0;
                SEDSTART  <= 1'b0;
                SEDFRCERR <= 1'b0;
                BUSY      <= 1'b0;
            end else if (wd_fire) begin
                // Stuck handshake: report a failed check and re-power SEDGA.
                state     <= ST_WARMUP;
                warm_cnt  <= '0;
                wd_cnt    <= '0;
                ivl_cnt   <= '0;
                SEDENABLE <= 1'b0;
                SEDSTART  <= 1'b0;
                SEDFRCERR <= 1'b0;
                CHKDONE   <= 1'b1;
                CHKERR    <= 1'b1;
                to_evt    <= 1'b1;
            end else begin
                if (wd_active) wd_cnt <= phase_exit ? '0 : wd_cnt + WD_W'(1);
                case (state)
                    ST_DISABLED: begin
                        state    <= ST_WARMUP;
                        warm_cnt <= '0;
                    end
                    ST_WARMUP: begin
                        SEDENABLE <= 1'b1;
                        if (warm_cnt == WARM_LAST) begin
                            state    <= ST_IDLE;
                            warm_cnt <= '0;
                            BUSY     <= 1'b0;
                        end else begin
                            warm_cnt <= warm_cnt + WARM_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (launch_req) begin
                            state     <= ST_LAUNCH;
                            pending   <= 1'b0;
                            wd_cnt    <= '0;
                            SEDSTART  <= 1'b1;
                            SEDFRCERR <= INJ;
                            BUSY      <= 1'b1;
                        end else if (INTERVAL != 0) begin
                            ivl_cnt <= ivl_cnt + IVL_W'(1);
                        end
                    end
                    ST_LAUNCH: begin
                        if (sinprog) state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (phase_exit) begin
                            state   <= ST_SETTLE;
                            set_cnt <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        if (set_cnt == SET_LAST) begin
                            state     <= ST_RELEASE;
                            SEDSTART  <= 1'b0;
                            SEDFRCERR <= 1'b0;
                            CHKDONE   <= 1'b1;
                            CHKERR    <= serr;
                        end else begin
                            set_cnt <= set_cnt + SET_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (phase_exit) begin
                            state   <= ST_IDLE;
                            ivl_cnt <= '0;
                            BUSY    <= 1'b0;
                        end
                    end
                    default: state <= ST_DISABLED;
                endcase
            end
        end
    end

    // Result bookkeeping trails CHKDONE by one cycle; CLR takes effect before a same-cycle error.
    assign err_evt  = CHKDONE & CHKERR;
    assign cnt_base = CLR ? '0 : ERRCNT;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ERRFLAG <= 1'b0;
            TOFLAG  <= 1'b0;
            ERRCNT  <= '0;
        end else begin
            ERRFLAG <= (ERRFLAG & ~CLR) | err_evt;
            TOFLAG  <= (TOFLAG & ~CLR) | to_evt;
            if (err_evt && (cnt_base != '1)) ERRCNT <= cnt_base + ERRCNT_W'(1);
            else                             ERRCNT <= cnt_base;
        end
    end

endmodule
